// File: rtl/can_header_decoder.sv
// can_header_decoder
// ------------------
// Walks the arbitration and control fields of a classical or FD CAN frame,
// one bus sample per sample-point strobe, and presents the decoded header
// (identifier, IDE, RTR/RRS, EDL, BRS, ESI, DLC) with a one-cycle HDR_VALID
// pulse. A recessive-run counter detects bus idle (11 recessive samples), so
// that start-of-frame is only accepted on an idle bus.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high
//   SP         sample-point strobe, one clk wide; qualifies RX and STUFF
//   RX         sampled bus bit (0 dominant, 1 recessive)
//   STUFF      current sample is a stuff bit
//   ABORT      error seen elsewhere; drop the frame and wait for bus idle
//   ID[28:0]   identifier; base frame in [10:0], extended base part in
//              [28:18] and extension in [17:0]
//   IDE        identifier-extension bit
//   RTR        raw RTR (classical) or RRS (FD) bit
//   EDL        FDF bit (r0 in base frames, r1 in extended frames)
//   BRS, ESI   FD-only flags, 0 when EDL=0
//   DLC[3:0]   data length code
//   HDR_VALID  one-cycle pulse when all header outputs have been updated
//   BUSY       high while a frame is being tracked (not WAIT_IDLE / IDLE)

module can_header_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        SP,
  input  logic        RX,
  input  logic        STUFF,
  input  logic        ABORT,
  output logic [28:0] ID,
  output logic        IDE,
  output logic        RTR,
  output logic        EDL,
  output logic        BRS,
  output logic        ESI,
  output logic [3:0]  DLC,
  output logic        HDR_VALID,
  output logic        BUSY
);

  // Field-level states of the header walk. WAIT_IDLE and IDLE are the only
  // states in which the block is not considered busy.
  typedef enum logic [3:0] {
    WAIT_IDLE,
    IDLE,
    BASE_ID,
    SRR_RTR,
    IDE_BIT,
    EXT_ID,
    EXT_RTR,
    FDF_BIT,
    R0_BIT,
    RES_BIT,
    BRS_BIT,
    ESI_BIT,
    DLC_BITS,
    TRAIL
  } state_t;

  localparam logic [3:0] IDLE_RUN = 4'd11;

  state_t      state;
  logic [3:0]  runCnt;
  logic [3:0]  runNext;
  logic        idleReached;
  logic [4:0]  bitCnt;

  logic [28:0] shId;
  logic        shIde;
  logic        shRtr;
  logic        shEdl;
  logic        shBrs;
  logic        shEsi;
  logic [3:0]  shDlc;

  // Next value of the recessive-run counter for the current sample. Every
  // sample counts, stuff bits included: a recessive sample extends the run
  // (saturating at 11) and a dominant one restarts it. idleReached tells the
  // FSM that this sample completes an idle period.
  always_comb begin
    runNext = runCnt;
    if (RX) begin
      if (runCnt != IDLE_RUN) begin
        runNext = runCnt + 4'd1;
      end
    end else begin
      runNext = 4'd0;
    end
    idleReached = (runNext == IDLE_RUN);
  end

  // BUSY is a pure decode of the state register, so it changes in the cycle
  // after the SP that moved the FSM.
  assign BUSY = (state != WAIT_IDLE) && (state != IDLE);

  // Main sequencer. The header is assembled in shadow registers while the
  // fields go by; the visible outputs only change together with HDR_VALID,
  // so the downstream stage never sees a half-built header. ABORT takes
  // priority over a simultaneous SP and throws the partial header away
  // without touching the outputs. Stuff samples feed the run counter but
  // leave field state and bit counters alone, which stretches the current
  // field by one sample point. The identifier is shifted in MSB first as a
  // single 29-bit shift register: after 11 bits a base ID sits in [10:0],
  // and after 18 more the base part has moved up into [28:18].
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_IDLE;
      runCnt    <= 4'd0;
      bitCnt    <= 5'd0;
      shId      <= 29'd0;
      shIde     <= 1'b0;
      shRtr     <= 1'b0;
      shEdl     <= 1'b0;
      shBrs     <= 1'b0;
      shEsi     <= 1'b0;
      shDlc     <= 4'd0;
      ID        <= 29'd0;
      IDE       <= 1'b0;
      RTR       <= 1'b0;
      EDL       <= 1'b0;
      BRS       <= 1'b0;
      ESI       <= 1'b0;
      DLC       <= 4'd0;
      HDR_VALID <= 1'b0;
    end else begin
      HDR_VALID <= 1'b0;
      if (ABORT) begin
        state  <= WAIT_IDLE;
        runCnt <= 4'd0;
        bitCnt <= 5'd0;
        shId   <= 29'd0;
        shIde  <= 1'b0;
        shRtr  <= 1'b0;
        shEdl  <= 1'b0;
        shBrs  <= 1'b0;
        shEsi  <= 1'b0;
        shDlc  <= 4'd0;
      end else if (SP) begin
        runCnt <= runNext;
        unique case (state)
          WAIT_IDLE: begin
            if (idleReached) begin
              state <= IDLE;
            end
          end
          IDLE: begin
            if (!STUFF && !RX) begin
              state  <= BASE_ID;
              bitCnt <= 5'd0;
              shId   <= 29'd0;
              shIde  <= 1'b0;
              shRtr  <= 1'b0;
              shEdl  <= 1'b0;
              shBrs  <= 1'b0;
              shEsi  <= 1'b0;
              shDlc  <= 4'd0;
            end
          end
          BASE_ID: begin
            if (!STUFF) begin
              shId <= {shId[27:0], RX};
              if (bitCnt == 5'd10) begin
                state  <= SRR_RTR;
                bitCnt <= 5'd0;
              end else begin
                bitCnt <= bitCnt + 5'd1;
              end
            end
          end
          SRR_RTR: begin
            if (!STUFF) begin
              shRtr <= RX;
              state <= IDE_BIT;
            end
          end
          IDE_BIT: begin
            if (!STUFF) begin
              shIde  <= RX;
              bitCnt <= 5'd0;
              state  <= RX ? EXT_ID : FDF_BIT;
            end
          end
          EXT_ID: begin
            if (!STUFF) begin
              shId <= {shId[27:0], RX};
              if (bitCnt == 5'd17) begin
                state  <= EXT_RTR;
                bitCnt <= 5'd0;
              end else begin
                bitCnt <= bitCnt + 5'd1;
              end
            end
          end
          EXT_RTR: begin
            if (!STUFF) begin
              shRtr <= RX;
              state <= FDF_BIT;
            end
          end
          FDF_BIT: begin
            if (!STUFF) begin
              shEdl  <= RX;
              bitCnt <= 5'd0;
              if (RX) begin
                state <= RES_BIT;
              end else if (shIde) begin
                state <= R0_BIT;
              end else begin
                state <= DLC_BITS;
              end
            end
          end
          R0_BIT: begin
            if (!STUFF) begin
              state <= DLC_BITS;
            end
          end
          RES_BIT: begin
            if (!STUFF) begin
              state <= BRS_BIT;
            end
          end
          BRS_BIT: begin
            if (!STUFF) begin
              shBrs <= RX;
              state <= ESI_BIT;
            end
          end
          ESI_BIT: begin
            if (!STUFF) begin
              shEsi  <= RX;
              bitCnt <= 5'd0;
              state  <= DLC_BITS;
            end
          end
          DLC_BITS: begin
            if (!STUFF) begin
              shDlc <= {shDlc[2:0], RX};
              if (bitCnt == 5'd3) begin
                state     <= TRAIL;
                bitCnt    <= 5'd0;
                HDR_VALID <= 1'b1;
                ID        <= shId;
                IDE       <= shIde;
                RTR       <= shRtr;
                EDL       <= shEdl;
                BRS       <= shBrs;
                ESI       <= shEsi;
                DLC       <= {shDlc[2:0], RX};
              end else begin
                bitCnt <= bitCnt + 5'd1;
              end
            end
          end
          TRAIL: begin
            if (idleReached) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= WAIT_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_header_decoder.sv
// tb_can_header_decoder
// ---------------------
// Table-driven bench for can_header_decoder. Each table entry describes a
// frame header and the decoded outputs expected for it; the bench serialises
// the header into bus samples (optionally with bit stuffing) and compares the
// outputs. Hand-written sequences cover idle qualification, ABORT and reset
// in the middle of a frame.

module tb_can_header_decoder;

  logic        clk;
  logic        reset;
  logic        SP;
  logic        RX;
  logic        STUFF;
  logic        ABORT;
  logic [28:0] ID;
  logic        IDE;
  logic        RTR;
  logic        EDL;
  logic        BRS;
  logic        ESI;
  logic [3:0]  DLC;
  logic        HDR_VALID;
  logic        BUSY;

  int total;
  int bad;
  int pulseTotal;

  typedef struct {
    logic [28:0] id;
    logic        ide;
    logic        srr;
    logic        rtr;
    logic        edl;
    logic        brs;
    logic        esi;
    logic [3:0]  dlc;
    bit          useStuff;
    logic [28:0] expId;
    logic        expIde;
    logic        expRtr;
    logic        expEdl;
    logic        expBrs;
    logic        expEsi;
    logic [3:0]  expDlc;
  } vec_t;

  vec_t vecs[6];
  logic [1:0] bitQ[$];

  can_header_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .SP        (SP),
    .RX        (RX),
    .STUFF     (STUFF),
    .ABORT     (ABORT),
    .ID        (ID),
    .IDE       (IDE),
    .RTR       (RTR),
    .EDL       (EDL),
    .BRS       (BRS),
    .ESI       (ESI),
    .DLC       (DLC),
    .HDR_VALID (HDR_VALID),
    .BUSY      (BUSY)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every cycle in which HDR_VALID is seen high, sampled mid-cycle.
  // A pulse longer than one cycle shows up as an extra count.
  initial pulseTotal = 0;
  always @(negedge clk) begin
    if (HDR_VALID) pulseTotal++;
  end

  // Drive one cycle of inputs on the falling edge, let the DUT see it on the
  // next rising edge, and return at the following falling edge with SP low.
  task automatic applyStimulus(input logic sp, input logic rx,
                               input logic stuff, input logic abort);
    @(negedge clk);
    SP    = sp;
    RX    = rx;
    STUFF = stuff;
    ABORT = abort;
    @(negedge clk);
    SP    = 1'b0;
    RX    = 1'b1;
    STUFF = 1'b0;
    ABORT = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendRecessive(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Serialise a header into bitQ as {stuff, rx} entries. Stuff bits are the
  // complement of a run of five identical bits and start a new run; none is
  // appended after the final DLC bit.
  task automatic buildFrame(input vec_t v);
    logic raw[$];
    logic lastBit;
    int   run;
    raw.push_back(1'b0);
    if (!v.ide) begin
      for (int k = 10; k >= 0; k--) raw.push_back(v.id[k]);
      raw.push_back(v.rtr);
      raw.push_back(1'b0);
    end else begin
      for (int k = 28; k >= 18; k--) raw.push_back(v.id[k]);
      raw.push_back(v.srr);
      raw.push_back(1'b1);
      for (int k = 17; k >= 0; k--) raw.push_back(v.id[k]);
      raw.push_back(v.rtr);
    end
    raw.push_back(v.edl);
    if (v.edl) begin
      raw.push_back(1'b0);
      raw.push_back(v.brs);
      raw.push_back(v.esi);
    end else if (v.ide) begin
      raw.push_back(1'b0);
    end
    for (int k = 3; k >= 0; k--) raw.push_back(v.dlc[k]);

    bitQ.delete();
    lastBit = 1'b0;
    run = 0;
    for (int i = 0; i < raw.size(); i++) begin
      bitQ.push_back({1'b0, raw[i]});
      if (run > 0 && raw[i] == lastBit) run++;
      else run = 1;
      lastBit = raw[i];
      if (v.useStuff && run == 5 && i != raw.size() - 1) begin
        bitQ.push_back({1'b1, ~raw[i]});
        lastBit = ~raw[i];
        run = 1;
      end
    end
  endtask

  task automatic sendBits(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(1'b1, bitQ[i][0], bitQ[i][1], 1'b0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ID"},        32'(ID),        32'h0);
    checkOutput({tag, ".IDE"},       32'(IDE),       32'h0);
    checkOutput({tag, ".RTR"},       32'(RTR),       32'h0);
    checkOutput({tag, ".EDL"},       32'(EDL),       32'h0);
    checkOutput({tag, ".BRS"},       32'(BRS),       32'h0);
    checkOutput({tag, ".ESI"},       32'(ESI),       32'h0);
    checkOutput({tag, ".DLC"},       32'(DLC),       32'h0);
    checkOutput({tag, ".HDR_VALID"}, 32'(HDR_VALID), 32'h0);
    checkOutput({tag, ".BUSY"},      32'(BUSY),      32'h0);
  endtask

  task automatic runVector(input int n);
    int    base;
    string tag;
    tag  = $sformatf("vec%0d", n);
    base = pulseTotal;
    buildFrame(vecs[n]);
    sendBits(0, bitQ.size() - 1);
    checkOutput({tag, ".hdrTiming"}, 32'(HDR_VALID), 32'h1);
    checkOutput({tag, ".ID"},  32'(ID),  32'(vecs[n].expId));
    checkOutput({tag, ".IDE"}, 32'(IDE), 32'(vecs[n].expIde));
    checkOutput({tag, ".RTR"}, 32'(RTR), 32'(vecs[n].expRtr));
    checkOutput({tag, ".EDL"}, 32'(EDL), 32'(vecs[n].expEdl));
    checkOutput({tag, ".BRS"}, 32'(BRS), 32'(vecs[n].expBrs));
    checkOutput({tag, ".ESI"}, 32'(ESI), 32'(vecs[n].expEsi));
    checkOutput({tag, ".DLC"}, 32'(DLC), 32'(vecs[n].expDlc));
    checkOutput({tag, ".busyTrail"}, 32'(BUSY), 32'h1);
    sendRecessive(11);
    checkOutput({tag, ".pulses"}, 32'(pulseTotal - base), 32'h1);
    checkOutput({tag, ".busyIdle"}, 32'(BUSY), 32'h0);
  endtask

  initial begin
    int base;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    SP    = 1'b0;
    RX    = 1'b1;
    STUFF = 1'b0;
    ABORT = 1'b0;

    vecs[0] = '{29'h123,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0,
                29'h123,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8};
    vecs[1] = '{29'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0,
                29'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2};
    vecs[2] = '{29'h7FF,      1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0,
                29'h7FF,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF};
    vecs[3] = '{29'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1,
                29'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[4] = '{29'h1ABCDEF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0,
                29'h1ABCDEF0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA};
    vecs[5] = '{29'h555,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1,
                29'h555,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkAllZero("reset");

    // Ten recessive samples are not enough to qualify idle.
    sendRecessive(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("idle10.BUSY", 32'(BUSY), 32'h0);

    // Eleven are, and the following dominant sample is a SOF.
    sendRecessive(11);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("idle11.BUSY", 32'(BUSY), 32'h1);

    // ABORT without SP drops the frame.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("abortNoSp.BUSY", 32'(BUSY), 32'h0);
    sendRecessive(11);

    for (int n = 0; n < 6; n++) runVector(n);

    // ABORT together with the 6th base-ID sample: no header, outputs held.
    base = pulseTotal;
    buildFrame(vecs[0]);
    sendBits(0, 5);
    checkOutput("abort.busyBefore", 32'(BUSY), 32'h1);
    applyStimulus(1'b1, bitQ[6][0], 1'b0, 1'b1);
    checkOutput("abort.BUSY", 32'(BUSY), 32'h0);
    sendBits(7, bitQ.size() - 1);
    checkOutput("abort.pulses", 32'(pulseTotal - base), 32'h0);
    checkOutput("abort.heldID",  32'(ID),  32'h555);
    checkOutput("abort.heldRTR", 32'(RTR), 32'h1);
    checkOutput("abort.heldDLC", 32'(DLC), 32'h3);
    sendRecessive(11);

    // Reset in the middle of the DLC field.
    base = pulseTotal;
    buildFrame(vecs[1]);
    sendBits(0, bitQ.size() - 3);
    checkOutput("midDlc.BUSY", 32'(BUSY), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkAllZero("midDlcReset");
    sendBits(bitQ.size() - 2, bitQ.size() - 1);
    repeat (2) @(negedge clk);
    checkOutput("midDlcReset.pulses", 32'(pulseTotal - base), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_header_decoder.md
# can_header_decoder

Sits directly upstream of the frame-type stage in the CAN decoder. Consumes the sampled bus bit at each sample-point strobe and walks the arbitration and control fields of a classical or FD frame. Produces identifier, IDE, RTR/RRS, EDL (FDF), BRS, ESI and DLC with a one-cycle valid pulse; RTR and EDL feed the frame-type stage. Tracks bus-idle (11 recessive samples) to qualify start-of-frame.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- SP  in  1  sample-point strobe, one clk cycle wide; RX/STUFF are valid only when SP=1.
- RX  in  1  sampled bus bit (0 dominant, 1 recessive).
- STUFF  in  1  current sample is a stuff bit; qualified by SP.
- ABORT  in  1  error detected elsewhere; returns block to WAIT_IDLE.
- ID  out  29  identifier; base frame in [10:0] with [28:11]=0; extended: base part [28:18], extension [17:0].
- IDE  out  1  identifier-extension bit.
- RTR  out  1  raw RTR (classical) / RRS (FD) bit.
- EDL  out  1  FDF bit (r0 base / r1 extended).
- BRS, ESI  out  1 each  FD only; 0 when EDL=0.
- DLC  out  4  data length code, MSB first on bus.
- HDR_VALID  out  1  one-cycle pulse, all header outputs updated.
- BUSY  out  1  high in every state except WAIT_IDLE and IDLE.

## Operation
- Advances only in clk cycles with SP=1. Samples with STUFF=1 do not advance field state or field bit counters, but do update the recessive-run counter.
- Run counter (4 bits, saturating at 11): RX=1 increments, RX=0 clears; counts all samples including stuff bits.
- States and transitions:
  - WAIT_IDLE: run counter reaching 11 -> IDLE.
  - IDLE: RX=0 (SOF) -> BASE_ID, bit counter=0.
  - BASE_ID: shift 11 bits MSB first -> SRR_RTR.
  - SRR_RTR: store bit as candidate RTR -> IDE.
  - IDE: IDE=0 -> FDF; IDE=1 -> EXT_ID.
  - EXT_ID: shift 18 bits -> EXT_RTR (overwrites RTR) -> FDF.
  - FDF: store EDL. EDL=1 -> RES. EDL=0: base -> DLC; extended -> R0 -> DLC.
  - RES -> BRS -> ESI -> DLC (BRS, ESI stored).
  - DLC: shift 4 bits; on 4th -> TRAIL, HDR_VALID next cycle.
  - TRAIL: run counter reaching 11 -> IDLE.
- Reserved bits (R0, RES) are not checked.
- Header fields are assembled in shadow registers; outputs load from them only together with HDR_VALID, and otherwise hold their values.
- ABORT=1 in any cycle, with or without SP: -> WAIT_IDLE, run counter=0, shadow registers cleared. Outputs hold. ABORT wins over a simultaneous SP.

## Timing
- Reset values:
  - All outputs 0.
  - State WAIT_IDLE, run counter 0.
  - Reset mid-frame discards the partial header; no HDR_VALID is issued.
- Latency: HDR_VALID and all header outputs are registered. They become valid in the clk cycle after the SP cycle that samples the last DLC bit. The pulse lasts exactly one cycle.
- Back-to-back: a SOF may be accepted at the first SP after the run counter reaches 11 in TRAIL.
- A stuff sample inside a field extends that field by one SP without changing counters.
- SOF seen in WAIT_IDLE is ignored. A recessive sample clears nothing in IDLE.

## Test plan
- Idle qualify: reset, then 10 recessive SPs, then dominant -> BUSY stays 0. Then 11 recessive SPs followed by dominant -> BUSY=1 at the next cycle.
- Base classical: ID=0x123, RTR=0, IDE=0, r0=0, DLC=8 -> one HDR_VALID; ID=0x123, IDE=0, RTR=0, EDL=0, DLC=4'h8.
- Extended remote: ID=0x12345678, SRR=1, IDE=1, RTR=1, r1=0, r0=0, DLC=2 -> ID=0x12345678, IDE=1, RTR=1, EDL=0, DLC=2.
- FD base: ID=0x7FF, RRS=0, IDE=0, FDF=1, res=0, BRS=1, ESI=0, DLC=0xF -> EDL=1, BRS=1, ESI=0, DLC=4'hF.
- Stuffing: base ID=0x000 with stuff bits (STUFF=1, RX=1) inserted after every 5 identical bits, DLC=0 -> ID=0, DLC=0. HDR_VALID occurs exactly 1 cycle after the last DLC SP.
- Abort and reset: ABORT coincident with the 6th BASE_ID SP -> no HDR_VALID, BUSY=0 next cycle, prior outputs held. Reset mid-DLC -> all outputs 0.
